// File: rtl/bs_pkg.sv
// Shared bitstream packer/extractor constants and the right-aligned field mask helper.
package bs_pkg;
  localparam int unsigned DATA_WD = 32;
  localparam int unsigned NUMB_WD = 5;
  localparam int unsigned BUF_WD  = 2 * DATA_WD;
  localparam int unsigned CNT_WD  = NUMB_WD + 2;

  // Mask of (numb + 1) ones, right-aligned.
  function automatic logic [DATA_WD-1:0] field_mask(input logic [NUMB_WD-1:0] numb);
    logic [DATA_WD-1:0] m;
    m = '1;
    return m >> (NUMB_WD'(DATA_WD - 1) - numb);
  endfunction
endpackage

// File: rtl/bs_split_shf.sv
// Field extraction and consume-shift for the bs_split buffer (pure combinational).
module bs_split_shf
  import bs_pkg::*;
(
  input  logic [BUF_WD-1:0]  bits_i,
  input  logic [NUMB_WD-1:0] numb_i,
  output logic [DATA_WD-1:0] fld_o,
  output logic [BUF_WD-1:0]  bits_o
);
  always_comb begin
    fld_o  = (bits_i[BUF_WD-1 -: DATA_WD] >> (NUMB_WD'(DATA_WD - 1) - numb_i))
             & field_mask(numb_i);
    bits_o = (bits_i << numb_i) << 1;
  end
endmodule

// File: rtl/bs_split.sv
// Bitstream extractor: buffers MSB-first words and returns 1..DATA_WD bit fields on request.
// Optional byte-realign input align_i when BS_SPLIT_ALIGN_EN is defined.
module bs_split
  import bs_pkg::*;
(
  input  logic               clk,
  input  logic               rstn,
`ifdef BS_SPLIT_ALIGN_EN
  input  logic               align_i,
`endif
  input  logic               wrd_val_i,
  input  logic [DATA_WD-1:0] wrd_dat_i,
  output logic               wrd_rdy_o,
  input  logic               req_i,
  input  logic [NUMB_WD-1:0] numb_i,
  output logic               req_rdy_o,
  output logic               val_o,
  output logic [DATA_WD-1:0] dat_o,
  output logic [CNT_WD-1:0]  cnt_o
);
  logic [BUF_WD-1:0]  bits_q, bits_d, shf_bits;
  logic [CNT_WD-1:0]  cnt_q, cnt_d, len;
  logic               val_q, val_d;
  logic [DATA_WD-1:0] dat_q, dat_d, shf_fld;
  logic               wrd_fire, req_fire;

  assign len       = CNT_WD'(numb_i) + CNT_WD'(1);
  assign wrd_rdy_o = (cnt_q <= CNT_WD'(DATA_WD));
`ifdef BS_SPLIT_ALIGN_EN
  assign req_rdy_o = ~align_i & (cnt_q >= len);
`else
  assign req_rdy_o = (cnt_q >= len);
`endif
  assign wrd_fire  = wrd_val_i & wrd_rdy_o;
  assign req_fire  = req_i & req_rdy_o;

  bs_split_shf u_shf (
    .bits_i (bits_q),
    .numb_i (numb_i),
    .fld_o  (shf_fld),
    .bits_o (shf_bits)
  );

  always_comb begin
    bits_d = bits_q;
    cnt_d  = cnt_q;
    val_d  = req_fire;
    dat_d  = dat_q;
    if (req_fire) begin
      bits_d = shf_bits;
      cnt_d  = cnt_q - len;
      dat_d  = shf_fld;
    end
`ifdef BS_SPLIT_ALIGN_EN
    if (align_i) begin
      bits_d = bits_q << cnt_q[2:0];
      cnt_d  = cnt_q - CNT_WD'(cnt_q[2:0]);
    end
`endif
    // Append after any consume; bits below the valid region are always zero.
    if (wrd_fire) begin
      bits_d = bits_d | ({wrd_dat_i, {DATA_WD{1'b0}}} >> cnt_d);
      cnt_d  = cnt_d + CNT_WD'(DATA_WD);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bits_q <= '0;
      cnt_q  <= '0;
      val_q  <= 1'b0;
      dat_q  <= '0;
    end else begin
      bits_q <= bits_d;
      cnt_q  <= cnt_d;
      val_q  <= val_d;
      dat_q  <= dat_d;
    end
  end

  assign val_o = val_q;
  assign dat_o = dat_q;
  assign cnt_o = cnt_q;
endmodule
